// File: rtl/alu_seq_exec.sv
// alu_seq_exec -- execute-stage ALU fed by the ALU control decoder.
//
// Single-cycle ops (AND, OR, XOR, SLL, SRL, ADD, SUB, SLT, BEQ, BNE, NOP)
// finish on the clock after start. MUL (unsigned shift-add) and DIV
// (unsigned restoring) iterate for WIDTH clocks.
//
// Optional feature macro: ALU_SEQ_DIV_EN
//   defined   -> divider datapath and DIV state are built.
//   undefined -> no divider; func 011001 behaves as NOP.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   1-cycle request, sampled only while busy=0
//   func[5:0]    in   function code from the ALU control decoder
//   a, b         in   operands (rs, rt/immediate)
//   result       out  low result / quotient
//   hi           out  MUL upper word / DIV remainder, 0 otherwise
//   branch_taken out  BEQ: a==b, BNE: a!=b, else 0
//   overflow     out  signed overflow for ADD/SUB
//   div_by_zero  out  DIV with b==0
//   busy         out  high while MUL/DIV iterate
//   done         out  1-cycle completion pulse
//   state_dbg    out  current FSM state (IDLE=0, MUL=1, DIV=2, DONE=3)
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0 (state IDLE or DONE); start while busy=1 is dropped, not queued.
// Each accepted request produces exactly one done pulse, and result/hi/flags
// are valid from that done cycle until the next done. Outputs only change on
// accept of a single-cycle op or on MUL/DIV completion.

module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             branch_taken,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_AND = 6'b000000;
    localparam logic [5:0] F_OR  = 6'b000001;
    localparam logic [5:0] F_XOR = 6'b000010;
    localparam logic [5:0] F_SLL = 6'b000011;
    localparam logic [5:0] F_SRL = 6'b000100;
    localparam logic [5:0] F_ADD = 6'b000101;
    localparam logic [5:0] F_SUB = 6'b000110;
    localparam logic [5:0] F_SLT = 6'b000111;
    localparam logic [5:0] F_BEQ = 6'b010011;
    localparam logic [5:0] F_BNE = 6'b010100;
    localparam logic [5:0] F_MUL = 6'b011000;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [5:0] F_DIV = 6'b011001;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] op_b;
    // Shared iteration registers: MUL keeps {partial product, multiplier},
    // DIV keeps {remainder, dividend/quotient}.
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;

    assign state_dbg = state;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] sum_ab;
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] sc_result;
    logic             sc_br;
    logic             sc_ov;

    always_comb begin
        sum_ab    = a + b;
        diff_ab   = a - b;
        sc_result = '0;
        sc_br     = 1'b0;
        sc_ov     = 1'b0;
        case (func)
            F_AND: sc_result = a & b;
            F_OR:  sc_result = a | b;
            F_XOR: sc_result = a ^ b;
            F_SLL: sc_result = a << b[SW-1:0];
            F_SRL: sc_result = a >> b[SW-1:0];
            F_ADD: begin
                sc_result = sum_ab;
                sc_ov     = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
            end
            F_SUB: begin
                sc_result = diff_ab;
                // SUB adds ~b, so "signs match after negation" means a and b differ.
                sc_ov     = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ab[WIDTH-1] != a[WIDTH-1]);
            end
            F_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            F_BEQ: begin
                sc_result = diff_ab;
                sc_br     = (a == b);
            end
            F_BNE: begin
                sc_result = diff_ab;
                sc_br     = (a != b);
            end
            default: ; // NOP and unknown codes: zeros
        endcase
    end

    logic is_mul;
    logic is_div;
    assign is_mul = (func == F_MUL);
`ifdef ALU_SEQ_DIV_EN
    assign is_div = (func == F_DIV);
`else
    assign is_div = 1'b0;
`endif

    // ---------------- MUL iteration (shift-add, LSB first) ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, p_lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    // ---------------- DIV iteration (restoring) ----------------
    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_q_next;
    assign div_shift    = {p_hi, p_lo[WIDTH-1]};
    assign div_diff     = div_shift - {1'b0, op_b};
    // With a nonzero divisor the remainder stays below b, so bit WIDTH of the
    // difference is a clean borrow flag.
    assign div_ge       = ~div_diff[WIDTH];
    assign div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_q_next   = {p_lo[WIDTH-2:0], div_ge};
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            op_b         <= '0;
            p_hi         <= '0;
            p_lo         <= '0;
            result       <= '0;
            hi           <= '0;
            branch_taken <= 1'b0;
            overflow     <= 1'b0;
            div_by_zero  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            op_a         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                    if (start) begin
                        if (is_mul) begin
                            op_b  <= b;
                            p_hi  <= '0;
                            p_lo  <= a;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= S_MUL;
                        end else if (is_div) begin
`ifdef ALU_SEQ_DIV_EN
                            op_a  <= a;
`endif
                            op_b  <= b;
                            p_hi  <= '0;
                            p_lo  <= a;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= S_DIV;
                        end else begin
                            result       <= sc_result;
                            hi           <= '0;
                            branch_taken <= sc_br;
                            overflow     <= sc_ov;
                            div_by_zero  <= 1'b0;
                            done         <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    {p_hi, p_lo} <= mul_next;
                    cnt          <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        result       <= mul_next[WIDTH-1:0];
                        hi           <= mul_next[2*WIDTH-1:WIDTH];
                        branch_taken <= 1'b0;
                        overflow     <= 1'b0;
                        div_by_zero  <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        cnt          <= '0;
                        state        <= S_DONE;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    p_hi <= div_rem_next;
                    p_lo <= div_q_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // b==0 still runs the full count; the result is forced
                        // because the borrow trick above assumes rem < b.
                        if (op_b == '0) begin
                            result      <= '1;
                            hi          <= op_a;
                            div_by_zero <= 1'b1;
                        end else begin
                            result      <= div_q_next;
                            hi          <= div_rem_next;
                            div_by_zero <= 1'b0;
                        end
                        branch_taken <= 1'b0;
                        overflow     <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        cnt          <= '0;
                        state        <= S_DONE;
                    end
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec (WIDTH=32). Inputs change and outputs are
// sampled on the falling clock edge. The DIV block adapts to ALU_SEQ_DIV_EN.

module tb_alu_seq_exec;

  localparam int W = 32;

  localparam logic [5:0] F_AND = 6'b000000;
  localparam logic [5:0] F_OR  = 6'b000001;
  localparam logic [5:0] F_XOR = 6'b000010;
  localparam logic [5:0] F_SLL = 6'b000011;
  localparam logic [5:0] F_SRL = 6'b000100;
  localparam logic [5:0] F_ADD = 6'b000101;
  localparam logic [5:0] F_SUB = 6'b000110;
  localparam logic [5:0] F_SLT = 6'b000111;
  localparam logic [5:0] F_BEQ = 6'b010011;
  localparam logic [5:0] F_BNE = 6'b010100;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam logic [5:0] F_DIV = 6'b011001;
  localparam logic [5:0] F_NOP = 6'b111111;

  logic         clock;
  logic         reset;
  logic         start;
  logic [5:0]   func;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic         branch_taken;
  logic         overflow;
  logic         div_by_zero;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  int checks;
  int failures;

  alu_seq_exec #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .func         (func),
    .a            (a),
    .b            (b),
    .result       (result),
    .hi           (hi),
    .branch_taken (branch_taken),
    .overflow     (overflow),
    .div_by_zero  (div_by_zero),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns at the falling edge after the
  // sampling rising edge, with start already dropped.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] va, input logic [W-1:0] vb);
    func  = f;
    a     = va;
    b     = vb;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Single-cycle op: done must be up right after issue.
  task automatic single(input string tag, input logic [5:0] f, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [W-1:0] exp_res,
                        input logic exp_br, input logic exp_ov);
    issue(f, va, vb);
    check({tag, ".done"}, {63'd0, done}, 64'd1);
    check({tag, ".result"}, {32'd0, result}, {32'd0, exp_res});
    check({tag, ".hi"}, {32'd0, hi}, 64'd0);
    check({tag, ".flags"}, {61'd0, branch_taken, overflow, div_by_zero}, {61'd0, exp_br, exp_ov, 1'b0});
  endtask

  // Multi-cycle op: counts busy cycles (bounded) and checks the result.
  task automatic multi(input string tag, input logic [5:0] f, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [W-1:0] exp_res,
                       input logic [W-1:0] exp_hi, input logic exp_dz);
    int bc;
    bc = 0;
    issue(f, va, vb);
    for (int i = 0; i < 100 && busy; i++) begin
      bc++;
      check({tag, ".no_early_done"}, {63'd0, done}, 64'd0);
      @(negedge clock);
    end
    check({tag, ".busy_cycles"}, 64'(bc), 64'(W));
    check({tag, ".done"}, {63'd0, done}, 64'd1);
    check({tag, ".result"}, {32'd0, result}, {32'd0, exp_res});
    check({tag, ".hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, ".dz"}, {63'd0, div_by_zero}, {63'd0, exp_dz});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bc;
    int done_cnt;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    func     = F_NOP;
    a        = '0;
    b        = '0;

    // Reset state
    #1;
    check("rst.result", {32'd0, result}, 64'd0);
    check("rst.hi", {32'd0, hi}, 64'd0);
    check("rst.ctl", {59'd0, branch_taken, overflow, div_by_zero, busy, done}, 64'd0);
    check("rst.state", {62'd0, state_dbg}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset in the middle of a MUL aborts it with no done
    issue(F_MUL, 32'd3, 32'd5);
    check("abort.busy_before", {63'd0, busy}, 64'd1);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort.busy", {63'd0, busy}, 64'd0);
    check("abort.outs", {32'd0, result | hi}, 64'd0);
    check("abort.state", {62'd0, state_dbg}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) done_cnt++;
    end
    check("abort.no_done", 64'(done_cnt), 64'd0);
    check("abort.result_held", {32'd0, result}, 64'd0);

    // ADD / SUB with overflow edges
    single("add_ovf", F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    @(negedge clock);
    check("add_ovf.done_pulse", {63'd0, done}, 64'd0);
    check("add_ovf.held", {32'd0, result}, 64'h0000_0000_8000_0000);
    single("sub_eq", F_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0);
    single("sub_ovf", F_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    single("add_neg", F_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Logic, shifts, SLT
    single("and", F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
    single("or",  F_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0);
    single("xor", F_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0);
    single("sll", F_SLL, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0, 1'b0);
    single("srl", F_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1'b0);
    single("slt_neg", F_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    single("slt_pos", F_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);

    // BEQ then BNE back-to-back: done on consecutive cycles
    func  = F_BEQ;
    a     = 32'h0000_1234;
    b     = 32'h0000_1234;
    start = 1'b1;
    @(negedge clock);
    check("beq.done", {63'd0, done}, 64'd1);
    check("beq.taken", {63'd0, branch_taken}, 64'd1);
    check("beq.result", {32'd0, result}, 64'd0);
    func = F_BNE;
    @(negedge clock);
    start = 1'b0;
    check("bne.done", {63'd0, done}, 64'd1);
    check("bne.taken", {63'd0, branch_taken}, 64'd0);
    @(negedge clock);
    check("bne.done_drop", {63'd0, done}, 64'd0);
    single("bne_diff", F_BNE, 32'd10, 32'd3, 32'd7, 1'b1, 1'b0);

    // MUL FFFFFFFF*2 with a stray start while busy
    bc = 0;
    issue(F_MUL, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 100 && busy; i++) begin
      bc++;
      if (i == 2) begin
        start = 1'b1;
        func  = F_ADD;
        a     = 32'd1;
        b     = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    check("mul_big.busy_cycles", 64'(bc), 64'd32);
    check("mul_big.done", {63'd0, done}, 64'd1);
    check("mul_big.result", {32'd0, result}, 64'h0000_0000_FFFF_FFFE);
    check("mul_big.hi", {32'd0, hi}, 64'd1);
    @(negedge clock);
    check("mul_big.no_queue_done", {63'd0, done}, 64'd0);
    check("mul_big.no_queue_res", {32'd0, result}, 64'h0000_0000_FFFF_FFFE);

    multi("mul_small", F_MUL, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0);
    multi("mul_carry", F_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1'b0);

    // Single-cycle op after MUL clears hi
    single("add_after_mul", F_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

    // DIV
`ifdef ALU_SEQ_DIV_EN
    multi("div", F_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    multi("div_zero", F_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b1);
    multi("div_max", F_DIV, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0);
`else
    single("div_off", F_DIV, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
    check("div_off.busy", {63'd0, busy}, 64'd0);
`endif

    // NOP behaviour (explicit and unknown code) after a nonzero result
    single("pre_nop", F_OR, 32'h0000_00FF, 32'h0000_FF00, 32'h0000_FFFF, 1'b0, 1'b0);
    single("nop", F_NOP, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    single("pre_unk", F_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    single("unknown", 6'b101010, 32'h1234_5678, 32'd1, 32'd0, 1'b0, 1'b0);

    @(negedge clock);
    check("final.idle", {62'd0, state_dbg}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
